// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB with combinational control outputs and a retired-instruction counter.
// Latency 2-5 cycles per instruction; memory backpressure (mem_ready=0) holds FETCH or MEM in place.
module multicycle_control (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  opcode,
    input  logic        zero,
    input  logic        neg,
    input  logic        mem_ready,
    output logic [2:0]  alu_op,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ir_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    localparam logic [3:0] OP_R    = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_ANDI = 4'd2;
    localparam logic [3:0] OP_ORI  = 4'd3;
    localparam logic [3:0] OP_SUBI = 4'd4;
    localparam logic [3:0] OP_LHW  = 4'd5;
    localparam logic [3:0] OP_SHW  = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;
    localparam logic [3:0] OP_BNE  = 4'd8;
    localparam logic [3:0] OP_BLT  = 4'd9;
    localparam logic [3:0] OP_BGT  = 4'd10;
    localparam logic [3:0] OP_JUMP = 4'd11;
    localparam logic [3:0] OP_RSTI = 4'd12;

    state_t cur;
    logic   is_branch;
    logic   br_taken;
    logic   is_illegal;
    logic   is_pc_load;
    logic   retire;

    assign state = cur;

    always_comb begin
        is_branch = 1'b0;
        br_taken  = 1'b0;
        case (opcode)
            OP_BEQ: begin is_branch = 1'b1; br_taken = zero;          end
            OP_BNE: begin is_branch = 1'b1; br_taken = !zero;         end
            OP_BLT: begin is_branch = 1'b1; br_taken = neg;           end
            OP_BGT: begin is_branch = 1'b1; br_taken = !neg && !zero; end
            default: ;
        endcase
    end

    assign is_illegal = (opcode > OP_RSTI);
    assign is_pc_load = (opcode == OP_JUMP) || (opcode == OP_RSTI);

    always_comb begin
        retire = 1'b0;
        case (cur)
            DECODE:  retire = is_pc_load;
            EXEC:    retire = is_branch;
            MEM:     retire = mem_ready && (opcode == OP_SHW);
            WB:      retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    // Every output is gated by reset so an in-flight access is dropped immediately.
    always_comb begin
        alu_op     = 3'b000;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        if (!reset) begin
            case (cur)
                FETCH: begin
                    mem_req   = 1'b1;
                    alu_op    = 3'b001;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: begin
                    alu_op    = 3'b001;
                    alu_src_b = 2'b10;
                    pc_write  = is_pc_load;
                    pc_src    = (opcode == OP_RSTI) ? 2'b11 : (opcode == OP_JUMP) ? 2'b10 : 2'b00;
                    illegal   = is_illegal;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    case (opcode)
                        OP_R:    alu_op = 3'b000;
                        OP_ADDI: begin alu_op = 3'b001; alu_src_b = 2'b10; end
                        OP_ANDI: begin alu_op = 3'b010; alu_src_b = 2'b10; end
                        OP_ORI:  begin alu_op = 3'b011; alu_src_b = 2'b10; end
                        OP_SUBI: begin alu_op = 3'b100; alu_src_b = 2'b10; end
                        OP_LHW, OP_SHW: begin alu_op = 3'b001; alu_src_b = 2'b10; end
                        default: begin
                            if (is_branch) begin
                                alu_op   = 3'b101;
                                pc_write = br_taken;
                                pc_src   = br_taken ? 2'b01 : 2'b00;
                            end
                        end
                    endcase
                end
                MEM: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = (opcode == OP_SHW);
                end
                WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = (opcode == OP_R);
                    mem_to_reg = (opcode == OP_LHW);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur         <= FETCH;
            instr_count <= 16'd0;
        end else begin
            if (retire)
                instr_count <= instr_count + 16'd1;
            case (cur)
                FETCH:  if (mem_ready) cur <= DECODE;
                DECODE: cur <= (is_pc_load || is_illegal) ? FETCH : EXEC;
                EXEC: begin
                    if (opcode <= OP_SUBI)
                        cur <= WB;
                    else if (opcode == OP_LHW || opcode == OP_SHW)
                        cur <= MEM;
                    else
                        cur <= FETCH;
                end
                MEM:    if (mem_ready) cur <= (opcode == OP_LHW) ? WB : FETCH;
                WB:     cur <= FETCH;
                default: cur <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboarded bench for multicycle_control: per-cycle expected state/controls/count queued with stimulus.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic        zero = 1'b0;
    logic        neg = 1'b0;
    logic        mem_ready = 1'b0;
    logic [2:0]  alu_op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        ir_write, mem_req, mem_we, iord, reg_write, reg_dst, mem_to_reg, illegal;
    logic [2:0]  state;
    logic [15:0] instr_count;
    logic [16:0] ctrl;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_cnt = 16'd0;

    // {alu_op, src_a, src_b, pc_write, pc_src, ir_write, mem_req, mem_we, iord, reg_write, reg_dst, mem_to_reg, illegal}
    localparam logic [16:0] C_FW   = {3'b001, 1'b0, 2'b01, 1'b0, 2'b00, 8'b0100_0000};
    localparam logic [16:0] C_FR   = {3'b001, 1'b0, 2'b01, 1'b1, 2'b00, 8'b1100_0000};
    localparam logic [16:0] C_DEC  = {3'b001, 1'b0, 2'b10, 1'b0, 2'b00, 8'b0000_0000};
    localparam logic [16:0] C_DILL = {3'b001, 1'b0, 2'b10, 1'b0, 2'b00, 8'b0000_0001};
    localparam logic [16:0] C_DJMP = {3'b001, 1'b0, 2'b10, 1'b1, 2'b10, 8'b0000_0000};
    localparam logic [16:0] C_DRST = {3'b001, 1'b0, 2'b10, 1'b1, 2'b11, 8'b0000_0000};
    localparam logic [16:0] C_XMEM = {3'b001, 1'b1, 2'b10, 1'b0, 2'b00, 8'b0000_0000};
    localparam logic [16:0] C_XBR  = {3'b101, 1'b1, 2'b00, 1'b0, 2'b00, 8'b0000_0000};
    localparam logic [16:0] C_XBT  = {3'b101, 1'b1, 2'b00, 1'b1, 2'b01, 8'b0000_0000};
    localparam logic [16:0] C_MLD  = {3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 8'b0101_0000};
    localparam logic [16:0] C_MST  = {3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 8'b0111_0000};
    localparam logic [16:0] C_WR   = {3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 8'b0000_1100};
    localparam logic [16:0] C_WI   = {3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 8'b0000_1000};
    localparam logic [16:0] C_WL   = {3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 8'b0000_1010};

    typedef struct packed {
        logic        rdy;
        logic        z;
        logic        n;
        logic [2:0]  st;
        logic [16:0] ctrl;
        logic [15:0] cnt;
    } ent_t;

    ent_t sb[$];

    assign ctrl = {alu_op, alu_src_a, alu_src_b, pc_write, pc_src,
                   ir_write, mem_req, mem_we, iord, reg_write, reg_dst, mem_to_reg, illegal};

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .neg(neg), .mem_ready(mem_ready),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_write(pc_write),
        .pc_src(pc_src), .ir_write(ir_write), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal(illegal),
        .state(state), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic push(input logic rdy, input logic z, input logic n,
                        input logic [2:0] st, input logic [16:0] c);
        ent_t e;
        e.rdy = rdy; e.z = z; e.n = n; e.st = st; e.ctrl = c; e.cnt = exp_cnt;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        ent_t e;
        mem_ready = 1'b1;
        opcode = 4'd6;
        #1 reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({state, ctrl, instr_count} !== 36'd0) begin
                failures++;
                $display("FAIL reset_hold%0d: st=%0d ctrl=%b cnt=%h, want all zero", i, state, ctrl, instr_count);
            end
        end
        @(posedge clk); #1 reset = 1'b0;
        push(1'b0, 1'b0, 1'b0, 3'd0, C_FW);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.rdy; zero = e.z; neg = e.n;
            @(negedge clk);
            checks++;
            if ({state, ctrl, instr_count} !== {e.st, e.ctrl, e.cnt}) begin
                failures++;
                $display("FAIL reset_release: st=%0d ctrl=%b cnt=%h want st=%0d ctrl=%b cnt=%h",
                         state, ctrl, instr_count, e.st, e.ctrl, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu();
        ent_t e;
        logic [2:0] aop [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
        for (int i = 0; i < 5; i++) begin
            opcode = 4'(i);
            push(1'b1, 1'b0, 1'b0, 3'd0, C_FR);
            push(1'b1, 1'b0, 1'b0, 3'd1, C_DEC);
            push(1'b1, 1'b0, 1'b0, 3'd2, {aop[i], 1'b1, (i == 0) ? 2'b00 : 2'b10, 1'b0, 2'b00, 8'b0});
            push(1'b1, 1'b0, 1'b0, 3'd4, (i == 0) ? C_WR : C_WI);
            exp_cnt++;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                mem_ready = e.rdy; zero = e.z; neg = e.n;
                @(negedge clk);
                checks++;
                if ({state, ctrl, instr_count} !== {e.st, e.ctrl, e.cnt}) begin
                    failures++;
                    $display("FAIL alu_op%0d: st=%0d ctrl=%b cnt=%h want st=%0d ctrl=%b cnt=%h",
                             i, state, ctrl, instr_count, e.st, e.ctrl, e.cnt);
                end
                @(posedge clk); #1;
            end
            checks++;
            if (state !== 3'd0 || instr_count !== exp_cnt) begin
                failures++;
                $display("FAIL alu_end%0d: st=%0d cnt=%h want st=0 cnt=%h", i, state, instr_count, exp_cnt);
            end
        end
    endtask

    task automatic test_lhw();
        ent_t e;
        opcode = 4'd5;
        push(1'b1, 1'b0, 1'b0, 3'd0, C_FR);
        push(1'b1, 1'b0, 1'b0, 3'd1, C_DEC);
        push(1'b0, 1'b0, 1'b0, 3'd2, C_XMEM);
        push(1'b0, 1'b0, 1'b0, 3'd3, C_MLD);
        push(1'b0, 1'b0, 1'b0, 3'd3, C_MLD);
        push(1'b1, 1'b0, 1'b0, 3'd3, C_MLD);
        push(1'b0, 1'b0, 1'b0, 3'd4, C_WL);
        exp_cnt++;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.rdy; zero = e.z; neg = e.n;
            @(negedge clk);
            checks++;
            if ({state, ctrl, instr_count} !== {e.st, e.ctrl, e.cnt}) begin
                failures++;
                $display("FAIL lhw: st=%0d ctrl=%b cnt=%h want st=%0d ctrl=%b cnt=%h",
                         state, ctrl, instr_count, e.st, e.ctrl, e.cnt);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (state !== 3'd0 || instr_count !== exp_cnt) begin
            failures++;
            $display("FAIL lhw_end: st=%0d cnt=%h want st=0 cnt=%h", state, instr_count, exp_cnt);
        end
    endtask

    task automatic test_branch();
        ent_t e;
        int ops [9] = '{7, 7, 8, 8, 9, 9, 10, 10, 10};
        logic zs [9] = '{1, 0, 0, 1, 0, 0, 0, 1, 0};
        logic ns [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
        logic tk [9] = '{1, 0, 1, 0, 1, 0, 1, 0, 0};
        for (int i = 0; i < 9; i++) begin
            opcode = 4'(ops[i]);
            push(1'b1, zs[i], ns[i], 3'd0, C_FR);
            push(1'b1, zs[i], ns[i], 3'd1, C_DEC);
            push(1'b1, zs[i], ns[i], 3'd2, tk[i] ? C_XBT : C_XBR);
            exp_cnt++;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                mem_ready = e.rdy; zero = e.z; neg = e.n;
                @(negedge clk);
                checks++;
                if ({state, ctrl, instr_count} !== {e.st, e.ctrl, e.cnt}) begin
                    failures++;
                    $display("FAIL branch%0d op%0d: st=%0d ctrl=%b cnt=%h want st=%0d ctrl=%b cnt=%h",
                             i, ops[i], state, ctrl, instr_count, e.st, e.ctrl, e.cnt);
                end
                @(posedge clk); #1;
            end
            checks++;
            if (state !== 3'd0 || instr_count !== exp_cnt) begin
                failures++;
                $display("FAIL branch_end%0d: st=%0d cnt=%h want st=0 cnt=%h", i, state, instr_count, exp_cnt);
            end
        end
    endtask

    task automatic test_decode_exits();
        ent_t e;
        int ops [4] = '{15, 13, 11, 12};
        for (int i = 0; i < 4; i++) begin
            opcode = 4'(ops[i]);
            push(1'b1, 1'b0, 1'b0, 3'd0, C_FR);
            push(1'b1, 1'b0, 1'b0, 3'd1, (ops[i] == 11) ? C_DJMP : (ops[i] == 12) ? C_DRST : C_DILL);
            if (ops[i] == 11 || ops[i] == 12)
                exp_cnt++;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                mem_ready = e.rdy; zero = e.z; neg = e.n;
                @(negedge clk);
                checks++;
                if ({state, ctrl, instr_count} !== {e.st, e.ctrl, e.cnt}) begin
                    failures++;
                    $display("FAIL decode op%0d: st=%0d ctrl=%b cnt=%h want st=%0d ctrl=%b cnt=%h",
                             ops[i], state, ctrl, instr_count, e.st, e.ctrl, e.cnt);
                end
                @(posedge clk); #1;
            end
            checks++;
            if (state !== 3'd0 || instr_count !== exp_cnt) begin
                failures++;
                $display("FAIL decode_end op%0d: st=%0d cnt=%h want st=0 cnt=%h", ops[i], state, instr_count, exp_cnt);
            end
        end
    endtask

    task automatic test_shw_reset();
        ent_t e;
        opcode = 4'd6;
        push(1'b0, 1'b0, 1'b0, 3'd0, C_FW);
        push(1'b1, 1'b0, 1'b0, 3'd0, C_FR);
        push(1'b0, 1'b0, 1'b0, 3'd1, C_DEC);
        push(1'b0, 1'b0, 1'b0, 3'd2, C_XMEM);
        push(1'b0, 1'b0, 1'b0, 3'd3, C_MST);
        push(1'b1, 1'b0, 1'b0, 3'd3, C_MST);
        exp_cnt++;
        // Second store is left stalled in MEM so reset lands mid-access.
        push(1'b1, 1'b0, 1'b0, 3'd0, C_FR);
        push(1'b0, 1'b0, 1'b0, 3'd1, C_DEC);
        push(1'b0, 1'b0, 1'b0, 3'd2, C_XMEM);
        push(1'b0, 1'b0, 1'b0, 3'd3, C_MST);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.rdy; zero = e.z; neg = e.n;
            @(negedge clk);
            checks++;
            if ({state, ctrl, instr_count} !== {e.st, e.ctrl, e.cnt}) begin
                failures++;
                $display("FAIL shw: st=%0d ctrl=%b cnt=%h want st=%0d ctrl=%b cnt=%h",
                         state, ctrl, instr_count, e.st, e.ctrl, e.cnt);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({state, ctrl, instr_count} !== 36'd0) begin
            failures++;
            $display("FAIL shw_abort: st=%0d ctrl=%b cnt=%h, want all zero", state, ctrl, instr_count);
        end
        exp_cnt = 16'd0;
        @(posedge clk); #1 reset = 1'b0;
        opcode = 4'd11;
        push(1'b0, 1'b0, 1'b0, 3'd0, C_FW);
        push(1'b1, 1'b0, 1'b0, 3'd0, C_FR);
        push(1'b0, 1'b0, 1'b0, 3'd1, C_DJMP);
        exp_cnt++;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.rdy; zero = e.z; neg = e.n;
            @(negedge clk);
            checks++;
            if ({state, ctrl, instr_count} !== {e.st, e.ctrl, e.cnt}) begin
                failures++;
                $display("FAIL shw_resume: st=%0d ctrl=%b cnt=%h want st=%0d ctrl=%b cnt=%h",
                         state, ctrl, instr_count, e.st, e.ctrl, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wrap();
        ent_t e;
        // Preload near the top of the range instead of retiring ~65k instructions.
        force dut.instr_count = 16'hFFFE;
        #1 release dut.instr_count;
        exp_cnt = 16'hFFFE;
        opcode = 4'd11;
        for (int i = 0; i < 2; i++) begin
            push(1'b1, 1'b0, 1'b0, 3'd0, C_FR);
            push(1'b1, 1'b0, 1'b0, 3'd1, C_DJMP);
            exp_cnt++;
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.rdy; zero = e.z; neg = e.n;
            @(negedge clk);
            checks++;
            if ({state, ctrl, instr_count} !== {e.st, e.ctrl, e.cnt}) begin
                failures++;
                $display("FAIL wrap: st=%0d ctrl=%b cnt=%h want st=%0d ctrl=%b cnt=%h",
                         state, ctrl, instr_count, e.st, e.ctrl, e.cnt);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (instr_count !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_end: cnt=%h want 0000", instr_count);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lhw();
        test_branch();
        test_decode_exits();
        test_shw_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all state SHALL be held in flops clocked on the rising edge of clk.
REQ-002 Port clk, input, 1: system clock.
REQ-003 Port reset, input, 1: asynchronous active-high reset.
REQ-004 Port opcode, input, 4: instruction opcode from the instruction register, valid from DECODE onward.
REQ-005 Port zero, input, 1: ALU result equals zero.
REQ-006 Port neg, input, 1: ALU result is negative.
REQ-007 Port mem_ready, input, 1: memory completes the current access this cycle.
REQ-008 Port alu_op, output, 3: ALU control class, where 000 = R-type (funct decides), 001 = add, 010 = and, 011 = or, 100 = sub, 101 = branch compare.
REQ-009 Port alu_src_a, output, 1: ALU operand A select, where 0 = PC and 1 = register A.
REQ-010 Port alu_src_b, output, 2: ALU operand B select, where 00 = register B, 01 = constant 1, 10 = sign-extended immediate.
REQ-011 Port pc_write, output, 1: PC load enable.
REQ-012 Port pc_src, output, 2: next-PC select, where 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = zero.
REQ-013 Ports ir_write, mem_req, mem_we, iord, reg_write, reg_dst, mem_to_reg, output, 1 each: IR load, memory request, memory write, address select (1 = ALUOut), register-file write, destination select (1 = rd), write-back source (1 = memory).
REQ-014 Port illegal, output, 1: single-cycle pulse when an unknown opcode is decoded.
REQ-015 Port state, output, 3: current state encoding.
REQ-016 Port instr_count, output, 16: count of retired instructions.

Function
REQ-017 State encodings SHALL be FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4; encodings 5-7 SHALL go to FETCH on the next edge.
REQ-018 The opcode map SHALL be: 0 R-type, 1 addi, 2 andi, 3 ori, 4 subi, 5 lhw, 6 shw, 7 beq, 8 bne, 9 blt, 10 bgt, 11 jump, 12 reset-instr; opcodes 13-15 are illegal.
REQ-019 Outputs SHALL be combinational from state, opcode, zero, neg and mem_ready; every output not listed for a state SHALL be 0.
REQ-020 FETCH SHALL drive mem_req=1, iord=0, alu_op=001, alu_src_a=0, alu_src_b=01, and SHALL hold while mem_ready=0.
REQ-021 When mem_ready=1 in FETCH, the block SHALL drive ir_write=1, pc_write=1 and pc_src=00, then move to DECODE.
REQ-022 DECODE SHALL drive alu_op=001, alu_src_a=0 and alu_src_b=10 to form the branch target.
REQ-023 In DECODE, jump SHALL drive pc_write=1 with pc_src=10 and go to FETCH.
REQ-024 In DECODE, reset-instr SHALL drive pc_write=1 with pc_src=11 and go to FETCH.
REQ-025 In DECODE, an illegal opcode SHALL drive illegal=1 and go to FETCH; all other opcodes SHALL go to EXEC.
REQ-026 EXEC SHALL drive alu_src_a=1 for every opcode.
REQ-027 In EXEC, R-type SHALL drive alu_op=000 and alu_src_b=00, then go to WB.
REQ-028 In EXEC, addi/andi/ori/subi SHALL drive alu_op=001/010/011/100 respectively with alu_src_b=10, then go to WB.
REQ-029 In EXEC, lhw/shw SHALL drive alu_op=001 and alu_src_b=10, then go to MEM.
REQ-030 In EXEC, branches SHALL drive alu_op=101 and alu_src_b=00, then go to FETCH.
REQ-031 A branch SHALL be taken when: beq and zero; bne and !zero; blt and neg; bgt and !neg and !zero; a taken branch SHALL drive pc_write=1 with pc_src=01.
REQ-032 MEM SHALL drive mem_req=1 and iord=1, with mem_we=1 for shw only, and SHALL hold while mem_ready=0.
REQ-033 When mem_ready=1 in MEM, shw SHALL go to FETCH and lhw SHALL go to WB.
REQ-034 WB SHALL drive reg_write=1, reg_dst=1 for R-type only and mem_to_reg=1 for lhw only, then go to FETCH.
REQ-035 instr_count SHALL increment by 1 on the edge leaving WB, MEM (shw), EXEC (branch, taken or not), or DECODE (jump, reset-instr).
REQ-036 instr_count SHALL NOT increment for an illegal opcode, and SHALL wrap from 0xFFFF to 0x0000.
REQ-037 mem_ready outside FETCH and MEM SHALL be ignored.

Reset
REQ-038 While reset=1, state SHALL be FETCH (0) and instr_count SHALL be 0, asynchronously.
REQ-039 While reset=1, every control output, including mem_req, SHALL be forced to 0.
REQ-040 Reset asserted mid-access SHALL abort the access immediately, with no write strobes.
REQ-041 The first rising edge after reset deasserts SHALL be a FETCH cycle with mem_req=1.

Verification
REQ-042 R-type with mem_ready=1 throughout: states 0,1,2,4,0; alu_op=000 in EXEC; reg_write=1 and reg_dst=1 for exactly one cycle; instr_count 0->1.
REQ-043 lhw with mem_ready low for 2 MEM cycles: MEM lasts 3 cycles with iord=1 and mem_we=0; WB has mem_to_reg=1; 7 cycles total from FETCH to the next FETCH.
REQ-044 beq with zero=1: pc_write=1 and pc_src=01 in EXEC; with zero=0: no pc_write in EXEC; both return to FETCH after 3 cycles and increment instr_count.
REQ-045 opcode=15: illegal=1 for one cycle in DECODE; no pc_write, reg_write or mem_we; instr_count unchanged.
REQ-046 Reset pulsed during MEM of shw with mem_ready=0: mem_req and mem_we drop the same cycle; state=0 and instr_count=0; fetch resumes after release.
REQ-047 instr_count preloaded to 0xFFFF by retiring 65535 instructions, then one jump: instr_count=0x0000.
